// File: rtl/clap_pkg.sv
// -----------------------------------------------------------------------------
// clap_pkg
// Shared definitions for the clap detection chain: the detector state
// encoding, a ceil(log2) helper for sizing counters, and the default
// threshold/duration constants that the energy stage and the light controller
// also build against.
// -----------------------------------------------------------------------------
package clap_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HIGH   = 3'd1,
        LOW    = 3'd2,
        GAP    = 3'd3,
        REJECT = 3'd4,
        EMIT   = 3'd5
    } clap_state_t;

    // Number of bits needed to hold the values 0 .. n-1 (at least one bit).
    function automatic int clogb2(input longint n);
        longint v;
        int     r;
        v = n - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r < 1) r = 1;
        return r;
    endfunction

    localparam int     DEFAULT_ENERGY_WIDTH    = 34;
    localparam int     DEFAULT_SUC_CLAPS_WIDTH = 16;
    localparam longint DEFAULT_K_H             = 128;
    localparam longint DEFAULT_K_L             = 32;
    localparam int     DEFAULT_N_H             = 64;
    localparam int     DEFAULT_N_L             = 12;
    localparam int     DEFAULT_N_D             = 12;
    localparam int     DEFAULT_MAX_CLAPS       = 4;

endpackage

// File: rtl/clap_sat_counter.sv
// -----------------------------------------------------------------------------
// clap_sat_counter
// Up-counter that saturates at MAX. clear and inc may be asserted together,
// which loads the value 1 (start of a new run in a single cycle).
//
// Ports:
//   clock  in   system clock
//   reset  in   asynchronous active-high reset, value returns to 0
//   clear  in   restart the count from 0
//   inc    in   add one (ignored when already at MAX)
//   value  out  current count
//   at_max out  value equals MAX
// -----------------------------------------------------------------------------
module clap_sat_counter #(
    parameter int     WIDTH = 8,
    parameter longint MAX   = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] value_next;

    always_comb begin
        base       = clear ? '0 : value;
        value_next = base;
        if (inc && (base != MAX_V)) begin
            value_next = base + WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else begin
            value <= value_next;
        end
    end

    assign at_max = (value == MAX_V);

endmodule

// File: rtl/clap_event_detector.sv
// -----------------------------------------------------------------------------
// clap_event_detector
// Classifies bursts in the per-window energy stream as claps (hysteresis
// between K_H and K_L, at most N_H loud samples, N_L quiet samples to
// confirm), counts successive claps until N_D quiet samples or MAX_CLAPS,
// then offers the count on a valid/ready stream. Over-long or interrupted
// bursts are dropped without touching the running clap count.
//
// Optional feature macro: CLAP_STATS_EN adds the reject_count port and its
// saturating counter; without it the FSM behaves identically.
//
// Ports:
//   clock            in   system clock
//   reset            in   asynchronous active-high reset
//   energy_data      in   unsigned window energy
//   energy_valid     in   energy sample offered
//   energy_ready     out  sample accepted this cycle when valid (0 in EMIT)
//   suc_claps_data   out  successive clap count, held while valid
//   suc_claps_valid  out  count offered
//   suc_claps_ready  in   downstream takes the count
//   reject_count     out  rejected bursts, saturating (CLAP_STATS_EN only)
// -----------------------------------------------------------------------------
module clap_event_detector
    import clap_pkg::*;
#(
    parameter int     ENERGY_WIDTH    = DEFAULT_ENERGY_WIDTH,
    parameter int     SUC_CLAPS_WIDTH = DEFAULT_SUC_CLAPS_WIDTH,
    parameter longint K_H             = DEFAULT_K_H,
    parameter longint K_L             = DEFAULT_K_L,
    parameter int     N_H             = DEFAULT_N_H,
    parameter int     N_L             = DEFAULT_N_L,
    parameter int     N_D             = DEFAULT_N_D,
    parameter int     MAX_CLAPS       = DEFAULT_MAX_CLAPS
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [ENERGY_WIDTH-1:0]    energy_data,
    input  logic                       energy_valid,
    output logic                       energy_ready,
    output logic [SUC_CLAPS_WIDTH-1:0] suc_claps_data,
    output logic                       suc_claps_valid,
    input  logic                       suc_claps_ready
`ifdef CLAP_STATS_EN
    ,
    output logic [15:0]                reject_count
`endif
);

    // hcnt runs 0 .. N_H+1, the others 0 .. their limit.
    localparam int HW = clogb2(longint'(N_H) + 2);
    localparam int LW = clogb2(longint'(N_L) + 1);
    localparam int GW = clogb2(longint'(N_D) + 1);

    localparam logic [ENERGY_WIDTH-1:0]    KH_T  = ENERGY_WIDTH'(K_H);
    localparam logic [ENERGY_WIDTH-1:0]    KL_T  = ENERGY_WIDTH'(K_L);
    localparam logic [HW-1:0]              NH_V  = HW'(N_H);
    localparam logic [LW-1:0]              NL_M1 = LW'(N_L - 1);
    localparam logic [GW-1:0]              ND_M1 = GW'(N_D - 1);
    localparam logic [SUC_CLAPS_WIDTH-1:0] MC_M1 = SUC_CLAPS_WIDTH'(MAX_CLAPS - 1);

    clap_state_t state, state_next;

    logic accept;
    logic loud;
    logic not_quiet;
    logic confirm;

    logic hcnt_clr, hcnt_inc;
    logic lcnt_clr, lcnt_inc;
    logic gcnt_clr, gcnt_inc;
    logic claps_clr, claps_inc;
    logic rej_inc;

    logic [HW-1:0]              hcnt;
    logic [LW-1:0]              lcnt;
    logic [GW-1:0]              gcnt;
    logic [SUC_CLAPS_WIDTH-1:0] claps;
    logic [SUC_CLAPS_WIDTH-1:0] claps_next;

    logic hcnt_at_max_unused;
    logic lcnt_at_max_unused;
    logic gcnt_at_max_unused;
    logic claps_at_max_unused;

    assign accept    = energy_valid & energy_ready;
    assign loud      = (energy_data >= KH_T);
    assign not_quiet = (energy_data >= KL_T);

    clap_sat_counter #(.WIDTH(HW), .MAX(longint'(N_H) + 1)) u_hcnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (hcnt_clr),
        .inc    (hcnt_inc),
        .value  (hcnt),
        .at_max (hcnt_at_max_unused)
    );

    clap_sat_counter #(.WIDTH(LW), .MAX(longint'(N_L))) u_lcnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (lcnt_clr),
        .inc    (lcnt_inc),
        .value  (lcnt),
        .at_max (lcnt_at_max_unused)
    );

    clap_sat_counter #(.WIDTH(GW), .MAX(longint'(N_D))) u_gcnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (gcnt_clr),
        .inc    (gcnt_inc),
        .value  (gcnt),
        .at_max (gcnt_at_max_unused)
    );

    clap_sat_counter #(.WIDTH(SUC_CLAPS_WIDTH), .MAX(longint'(MAX_CLAPS))) u_claps (
        .clock  (clock),
        .reset  (reset),
        .clear  (claps_clr),
        .inc    (claps_inc),
        .value  (claps),
        .at_max (claps_at_max_unused)
    );

`ifdef CLAP_STATS_EN
    logic rej_at_max_unused;

    clap_sat_counter #(.WIDTH(16), .MAX(longint'(16'hFFFF))) u_reject (
        .clock  (clock),
        .reset  (reset),
        .clear  (1'b0),
        .inc    (rej_inc),
        .value  (reject_count),
        .at_max (rej_at_max_unused)
    );
`else
    logic rej_inc_unused;
    assign rej_inc_unused = rej_inc;
`endif

    // Next state and counter controls; every counter action is tied to an
    // accepted sample except the claps clear on the output handshake.
    always_comb begin
        state_next = state;
        hcnt_clr   = 1'b0;
        hcnt_inc   = 1'b0;
        lcnt_clr   = 1'b0;
        lcnt_inc   = 1'b0;
        gcnt_clr   = 1'b0;
        gcnt_inc   = 1'b0;
        claps_clr  = 1'b0;
        claps_inc  = 1'b0;
        rej_inc    = 1'b0;
        confirm    = 1'b0;

        case (state)
            IDLE: begin
                if (accept && loud) begin
                    state_next = HIGH;
                    hcnt_clr   = 1'b1;
                    hcnt_inc   = 1'b1;
                end
            end

            HIGH: begin
                if (accept) begin
                    if (not_quiet) begin
                        hcnt_inc = 1'b1;
                        // The incremented count would exceed N_H.
                        if (hcnt >= NH_V) begin
                            state_next = REJECT;
                            rej_inc    = 1'b1;
                        end
                    end else begin
                        lcnt_clr   = 1'b1;
                        lcnt_inc   = 1'b1;
                        state_next = LOW;
                        if (N_L == 1) begin
                            confirm = 1'b1;
                        end
                    end
                end
            end

            LOW: begin
                if (accept) begin
                    if (not_quiet) begin
                        state_next = REJECT;
                        rej_inc    = 1'b1;
                    end else begin
                        lcnt_inc = 1'b1;
                        if (lcnt >= NL_M1) begin
                            confirm = 1'b1;
                        end
                    end
                end
            end

            GAP: begin
                if (accept) begin
                    if (loud) begin
                        state_next = HIGH;
                        hcnt_clr   = 1'b1;
                        hcnt_inc   = 1'b1;
                    end else begin
                        gcnt_inc = 1'b1;
                        if (gcnt >= ND_M1) begin
                            state_next = EMIT;
                        end
                    end
                end
            end

            REJECT: begin
                if (accept && !not_quiet) begin
                    if (claps != '0) begin
                        state_next = GAP;
                        gcnt_clr   = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            EMIT: begin
                if (suc_claps_ready) begin
                    state_next = IDLE;
                    claps_clr  = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // A confirmed clap either hits the cap (emit immediately) or opens
        // a new gap window.
        if (confirm) begin
            claps_inc = 1'b1;
            if (claps == MC_M1) begin
                state_next = EMIT;
            end else begin
                state_next = GAP;
                gcnt_clr   = 1'b1;
            end
        end
    end

    always_comb begin
        claps_next = claps_clr ? '0 : claps;
        if (claps_inc) begin
            claps_next = claps_next + SUC_CLAPS_WIDTH'(1);
        end
    end

    // Outputs are derived from the next state so they line up with the
    // state register and stay registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            energy_ready    <= 1'b0;
            suc_claps_valid <= 1'b0;
            suc_claps_data  <= '0;
        end else begin
            state           <= state_next;
            energy_ready    <= (state_next != EMIT);
            suc_claps_valid <= (state_next == EMIT);
            suc_claps_data  <= (state_next == EMIT) ? claps_next : '0;
        end
    end

endmodule

// File: tb/tb_clap_event_detector.sv
// -----------------------------------------------------------------------------
// tb_clap_event_detector
// Directed stimulus with a scoreboard queue of expected clap counts; a
// monitor on the falling edge pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_clap_event_detector;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [33:0] energy_data = '0;
    logic        energy_valid = 1'b0;
    logic        energy_ready;
    logic [15:0] suc_claps_data;
    logic        suc_claps_valid;
    logic        suc_claps_ready = 1'b1;
`ifdef CLAP_STATS_EN
    logic [15:0] reject_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] expq[$];

    always #5 clock = ~clock;

    clap_event_detector #(
        .ENERGY_WIDTH    (34),
        .SUC_CLAPS_WIDTH (16),
        .K_H             (128),
        .K_L             (32),
        .N_H             (4),
        .N_L             (2),
        .N_D             (3),
        .MAX_CLAPS       (3)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .energy_data     (energy_data),
        .energy_valid    (energy_valid),
        .energy_ready    (energy_ready),
        .suc_claps_data  (suc_claps_data),
        .suc_claps_valid (suc_claps_valid),
        .suc_claps_ready (suc_claps_ready)
`ifdef CLAP_STATS_EN
        ,
        .reject_count    (reject_count)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake must match the oldest expected count, and the
    // input side must be stalled while a count is offered.
    always @(negedge clock) begin
        if (!reset && suc_claps_valid) begin
            chk("emit_energy_ready", 64'(energy_ready), 64'd0);
            if (suc_claps_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_emit: got data %0d expected no emission at %0t",
                             suc_claps_data, $time);
                end else begin
                    chk("emit_data", 64'(suc_claps_data), 64'(expq.pop_front()));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the sample is taken.
    task automatic send(input logic [33:0] e);
        int n;
        n = 0;
        energy_data  = e;
        energy_valid = 1'b1;
        @(negedge clock);
        while (!energy_ready && n < 50) begin
            n++;
            @(negedge clock);
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: energy_ready 0 expected 1 within 50 cycles");
        end
        @(posedge clock);
        #1;
        energy_valid = 1'b0;
    endtask

    task automatic send_rep(input logic [33:0] e, input int n);
        for (int i = 0; i < n; i++) send(e);
    endtask

    task automatic single_clap();
        send_rep(34'd200, 2);
        send_rep(34'd10, 5);
    endtask

    // Valid must already be up on the cycle after the last sample; the
    // monitor pops on that same edge, then the output must drop next cycle.
    task automatic expect_emit_then_idle(input string name);
        @(negedge clock);
        chk({name, "_latency"}, 64'(suc_claps_valid), 64'd1);
        @(posedge clock);
        #1;
        chk({name, "_valid_low"}, 64'(suc_claps_valid), 64'd0);
        chk({name, "_ready_high"}, 64'(energy_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("reset_valid", 64'(suc_claps_valid), 64'd0);
        chk("reset_data", 64'(suc_claps_data), 64'd0);
        chk("reset_energy_ready", 64'(energy_ready), 64'd0);
`ifdef CLAP_STATS_EN
        chk("reset_reject_count", 64'(reject_count), 64'd0);
`endif
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("ready_after_release", 64'(energy_ready), 64'd1);

        // Single clap
        expq.push_back(16'd1);
        single_clap();
        expect_emit_then_idle("single");

        // Double clap, the 50 is held in HIGH by hysteresis
        expq.push_back(16'd2);
        send(34'd200);
        send_rep(34'd10, 2);
        send(34'd200);
        send(34'd50);
        send_rep(34'd10, 5);
        expect_emit_then_idle("double");

        // Long burst is rejected and the detector returns to idle
        send_rep(34'd200, 5);
        send(34'd10);
        repeat (6) @(posedge clock);
        #1;
        chk("burst_no_emit", 64'(suc_claps_valid), 64'd0);
`ifdef CLAP_STATS_EN
        chk("burst_reject_count", 64'(reject_count), 64'd1);
`endif
        expq.push_back(16'd1);
        single_clap();
        expect_emit_then_idle("after_burst");

        // Cap: third confirmed clap emits without waiting for a gap
        expq.push_back(16'd3);
        for (int i = 0; i < 3; i++) begin
            send(34'd200);
            send_rep(34'd10, 2);
        end
        expect_emit_then_idle("cap");

        // Backpressure
        suc_claps_ready = 1'b0;
        expq.push_back(16'd1);
        single_clap();
        @(negedge clock);
        chk("bp_latency", 64'(suc_claps_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("bp_valid_held", 64'(suc_claps_valid), 64'd1);
            chk("bp_data_held", 64'(suc_claps_data), 64'd1);
        end
        @(posedge clock);
        #1;
        suc_claps_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("bp_valid_low", 64'(suc_claps_valid), 64'd0);
        chk("bp_ready_high", 64'(energy_ready), 64'd1);

        // Reset in the middle of a burst
        send_rep(34'd200, 2);
        reset = 1'b1;
        #1;
        chk("midreset_valid", 64'(suc_claps_valid), 64'd0);
        chk("midreset_data", 64'(suc_claps_data), 64'd0);
        chk("midreset_energy_ready", 64'(energy_ready), 64'd0);
`ifdef CLAP_STATS_EN
        chk("midreset_reject_count", 64'(reject_count), 64'd0);
`endif
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        send_rep(34'd10, 10);
        repeat (10) @(posedge clock);
        #1;
        chk("midreset_no_emit", 64'(suc_claps_valid), 64'd0);
        expq.push_back(16'd1);
        single_clap();
        expect_emit_then_idle("after_reset");

        repeat (3) @(posedge clock);
        #1;
        chk("scoreboard_drained", 64'(expq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clap_event_detector.md
# clap_event_detector

Parametrised successor to the energy→clap→successive-claps chain. Consumes the per-window energy stream from the energy stage and classifies bursts as claps using hysteresis thresholds and min/max duration windows. Counts successive claps until a quiet gap or a count cap. Emits the count on a valid/ready stream to the light controller, with backpressure and explicit rejection of over-long bursts.

## Interface
- ENERGY_WIDTH, 34: energy sample width.
- SUC_CLAPS_WIDTH, 16: clap count width.
- K_H, 128: loud threshold; energy ≥ K_H starts a burst.
- K_L, 32: quiet threshold; energy < K_L is quiet. K_L ≤ K_H required.
- N_H, 64: max loud samples per clap, ≥1.
- N_L, 12: quiet samples confirming a clap, ≥1.
- N_D, 12: quiet samples after the last clap that end a sequence, ≥1.
- MAX_CLAPS, 4: sequence cap, 1..2^SUC_CLAPS_WIDTH-1.
- clock  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high.
- energy_data  in  ENERGY_WIDTH  unsigned energy.
- energy_valid  in  1  energy handshake.
- energy_ready  out  1  energy handshake.
- suc_claps_data  out  SUC_CLAPS_WIDTH  successive clap count.
- suc_claps_valid  out  1  count handshake.
- suc_claps_ready  in  1  count handshake.
- reject_count  out  16  saturating rejected-burst counter (only with CLAP_STATS_EN).

## Operation
- One FSM step per accepted sample (energy_valid & energy_ready). Counters: hcnt, lcnt, gcnt, claps.
- IDLE: e ≥ K_H → HIGH, hcnt=1; else stay.
- HIGH: e ≥ K_L → hcnt+1; if the new value exceeds N_H → REJECT. e < K_L → LOW, lcnt=1. If N_L=1 this sample confirms the clap (see LOW).
- LOW: e < K_L → lcnt+1. Reaching N_L confirms a clap: claps+1, then EMIT if claps = MAX_CLAPS, else GAP with gcnt=0. e ≥ K_L before N_L → REJECT.
- GAP: e ≥ K_H → HIGH, hcnt=1, claps kept. Otherwise gcnt+1; reaching N_D → EMIT.
- REJECT: burst discarded, claps unchanged; reject_count+1 on entry. Leaves on the first e < K_L: to GAP (gcnt=0) if claps>0, else IDLE.
- EMIT: suc_claps_valid=1, suc_claps_data=claps. On handshake → IDLE, claps=0.
- energy_ready=1 in every state except EMIT; 0 while reset is asserted.
- Comparisons are unsigned at full ENERGY_WIDTH. K_H/K_L are truncated to ENERGY_WIDTH.
- hcnt saturates at N_H+1; lcnt/gcnt are sized to clogb2 of their limit.

## Timing
- Reset values: state IDLE, all counters 0, suc_claps_valid=0, suc_claps_data=0, reject_count=0. energy_ready=0 during reset, 1 on the first edge after release.
- All outputs are registered. State updates on the edge that accepts the sample.
- suc_claps_valid rises the cycle after the N_D-th gap sample, or after the clap that reaches MAX_CLAPS.
- suc_claps_data is stable while valid and not ready.
- Valid & ready in cycle t → valid=0 and energy_ready=1 in cycle t+1. No back-to-back emissions; minimum 2-cycle emission period.
- energy_valid while in EMIT is not accepted (ready=0); the upstream holds the sample.
- Reset mid-sequence discards all partial counts; no emission follows.

## Configuration
- CLAP_STATS_EN defined: reject_count port and counter present. It saturates at 16'hFFFF and clears only on reset.
- Undefined: port and logic absent; FSM behaviour is identical.

## Structure
- Package clap_pkg holds:
  - state enum (IDLE, HIGH, LOW, GAP, REJECT, EMIT);
  - clogb2 function;
  - default threshold/duration constants shared with the energy stage and the light controller.
- One sub-module, clap_sat_counter (WIDTH, MAX; clear, inc, value, at_max), instanced for hcnt, lcnt, gcnt, claps and reject_count.

## Test plan
Common settings: K_H=128, K_L=32, N_H=4, N_L=2, N_D=3, MAX_CLAPS=3, always-valid input.
- Single clap: energies 200,200,10,10,10,10,10 → valid with data=1 one cycle after the 7th sample; then IDLE.
- Double clap: 200,10,10,200,50,10,10,10,10,10 → data=2. The 50 keeps HIGH via hysteresis.
- Long burst: 200×5, 10 → no emission; reject_count=1; state IDLE.
- Cap: three claps 200,10,10 repeated → valid right after the 3rd confirm, with no gap wait and data=3.
- Backpressure: hold suc_claps_ready=0 for 10 cycles after valid → data/valid stable, energy_ready=0. Ready=1 → handshake; next cycle valid=0, energy_ready=1.
- Reset asserted in HIGH after 200,200 → outputs zero immediately. After release, 10×10 → no emission.
